// File: rtl/fpadd_arb.sv
// fpadd_arb: two-requester round-robin arbiter in front of one shared
// floating-point adder. Operands of the granted requester are registered
// onto the adder, the arbiter waits for completion (or a timeout) and
// returns the result tagged with the owner id. Only one operation is ever
// outstanding at the adder.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req0/req1           operation requests, held until ack
//   a0,b0 / a1,b1       IEEE-754 single operands of each requester
//   ack0/ack1           one-cycle pulse: operands captured
//   rsp_valid           one-cycle pulse: rsp_id/rsp_sum/rsp_err are valid
//   rsp_id              owner of the response (0 or 1)
//   rsp_sum             adder result, or quiet NaN on timeout
//   rsp_err             response is a timeout, not a real sum
//   busy                high in every state except IDLE
//   add_start           start pulse to the shared adder
//   add_a/add_b         registered operands to the adder
//   add_sum/add_done    adder result and completion strobe
module fpadd_arb #(
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic        rsp_err,
    output logic        busy,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_done
);

    // Wide enough to hold TIMEOUT itself, so the counter can never wrap.
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN       = 32'h7FC0_0000;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic          last_id;
    logic          owner;
    logic [TW-1:0] timer;
    logic          grant_id;

    // Round-robin: on a tie the requester that was not served last wins;
    // a lone requester is always granted.
    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) grant_id = ~last_id;
        else              grant_id = req1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_id   <= 1'b1;
            owner     <= 1'b0;
            timer     <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            // Pulse outputs default low; set only on the transition into
            // the state that owns them so they are high for exactly one cycle.
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            add_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= grant_id;
                        last_id   <= grant_id;
                        add_a     <= grant_id ? a1 : a0;
                        add_b     <= grant_id ? b1 : b0;
                        ack0      <= ~grant_id;
                        ack1      <= grant_id;
                        add_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Done is tested first so a completion landing on the
                    // last timeout cycle still returns the real sum.
                    if (add_done) begin
                        rsp_sum   <= add_sum;
                        rsp_err   <= 1'b0;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        rsp_sum   <= QNAN;
                        rsp_err   <= 1'b1;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_arb.sv
// Self-checking bench for fpadd_arb with a behavioural shared adder whose
// completion latency (and whether it completes at all) is adjustable.
module tb_fpadd_arb;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, add_start;
    logic [31:0] rsp_sum, add_a, add_b;
    logic [31:0] add_sum = '0;
    logic        add_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0;
    int n_rsp = 0;
    logic [33:0] sb[$];   // {id, sum, err}

    int mdl_lat = 5;
    bit mdl_en = 1'b1;
    bit m_busy = 1'b0;
    int m_cnt = 0;
    logic [31:0] ma = '0, mb = '0;

    fpadd_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h3FC00000, 32'h40200000}: return 32'h40800000;
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            default:                      return x ^ y;
        endcase
    endfunction

    // Behavioural adder: done rises mdl_lat cycles after the start cycle.
    // Deliberately not reset so a stale completion can reach the DUT.
    always @(posedge clk) begin
        add_done <= 1'b0;
        if (add_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            ma     <= add_a;
            mb     <= add_b;
        end else if (m_busy) begin
            if (m_cnt == mdl_lat - 1) begin
                m_busy <= 1'b0;
                if (mdl_en) begin
                    add_done <= 1'b1;
                    add_sum  <= fadd(ma, mb);
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Scoreboard: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (add_start) n_start++;
        if (rsp_valid) begin
            n_rsp++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got id=%0d sum=%h err=%0d, required no response",
                         rsp_id, rsp_sum, rsp_err);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_sum, rsp_err} !== e) begin
                    errors++;
                    $display("FAIL rsp_content got id=%0d sum=%h err=%0d, required id=%0d sum=%h err=%0d",
                             rsp_id, rsp_sum, rsp_err, e[33], e[32:1], e[0]);
                end
            end
        end
    end

    // Raise one request, wait for its ack (bounded); s = START cycle or -1.
    task automatic issue(input bit id, input logic [31:0] x, input logic [31:0] y, output int s);
        s = -1;
        @(negedge clk);
        if (id) begin a1 = x; b1 = y; req1 = 1'b1; end
        else    begin a0 = x; b0 = y; req0 = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id && ack1) || (!id && ack0)) begin
                s = cyc;
                break;
            end
        end
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; r = its cycle or -1.
    task automatic wait_rsp(input int bound, output int r);
        r = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, add_start} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b, required 0000000",
                     {ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, add_start});
        end
        checks++;
        if ({rsp_sum, add_a, add_b} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got sum=%h a=%h b=%h, required zeros", rsp_sum, add_a, add_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int s, r;
        sb.push_back({1'b0, 32'h40000000, 1'b0});
        issue(1'b0, 32'h3F800000, 32'h3F800000, s);
        checks++;
        if ({ack0, ack1, add_start, busy} !== 4'b1011) begin
            errors++;
            $display("FAIL single_ack got ack0=%0d ack1=%0d start=%0d busy=%0d, required 1 0 1 1",
                     ack0, ack1, add_start, busy);
        end
        checks++;
        if ({add_a, add_b} !== {32'h3F800000, 32'h3F800000}) begin
            errors++;
            $display("FAIL single_operands got %h %h, required 3f800000 3f800000", add_a, add_b);
        end
        wait_rsp(30, r);
        checks++;
        if (s < 0 || r != s + 6) begin
            errors++;
            $display("FAIL single_latency got start=%0d rsp=%0d, required rsp=start+6", s, r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({rsp_id, rsp_sum, rsp_err, busy, rsp_valid} !== {1'b0, 32'h40000000, 3'b000}) begin
            errors++;
            $display("FAIL single_hold got id=%0d sum=%h err=%0d busy=%0d vld=%0d, required 0 40000000 0 0 0",
                     rsp_id, rsp_sum, rsp_err, busy, rsp_valid);
        end
    endtask

    task automatic test_tie();
        int ord[$];
        do_reset();
        sb.push_back({1'b0, 32'h40000000, 1'b0});
        sb.push_back({1'b1, 32'h40800000, 1'b0});
        a0 = 32'h3F800000; b0 = 32'h3F800000;
        a1 = 32'h3FC00000; b1 = 32'h40200000;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 100 && !(ord.size() == 2 && sb.size() == 0); i++) begin
            @(negedge clk);
            if (ack0) begin ord.push_back(0); req0 = 1'b0; end
            if (ack1) begin ord.push_back(1); req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (ord.size() != 2 || ord[0] != 0 || ord[1] != 1) begin
            errors++;
            $display("FAIL tie_order got %p, required '{0,1}", ord);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL tie_pending got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] op_a0[2] = '{32'h3F800000, 32'h40000000};
        logic [31:0] op_b0[2] = '{32'h40000000, 32'h40000000};
        logic [31:0] op_a1[2] = '{32'h3FC00000, 32'h3F800000};
        logic [31:0] op_b1[2] = '{32'h40200000, 32'h3F800000};
        int ord[$];
        int k0 = 0, k1 = 0;
        int st0 = n_start, rs0 = n_rsp;
        sb.push_back({1'b0, 32'h40400000, 1'b0});
        sb.push_back({1'b1, 32'h40800000, 1'b0});
        sb.push_back({1'b0, 32'h40800000, 1'b0});
        sb.push_back({1'b1, 32'h40000000, 1'b0});
        for (int i = 0; i < 200 && n_rsp < rs0 + 4; i++) begin
            @(negedge clk);
            if (ack0) begin ord.push_back(0); k0++; req0 = 1'b0; end
            else if (k0 < 2 && !req0) begin a0 = op_a0[k0]; b0 = op_b0[k0]; req0 = 1'b1; end
            if (ack1) begin ord.push_back(1); k1++; req1 = 1'b0; end
            else if (k1 < 2 && !req1) begin a1 = op_a1[k1]; b1 = op_b1[k1]; req1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (ord.size() != 4 || ord[0] != 0 || ord[1] != 1 || ord[2] != 0 || ord[3] != 1) begin
            errors++;
            $display("FAIL rr_order got %p, required '{0,1,0,1}", ord);
        end
        checks++;
        if (n_start - st0 != 4 || n_rsp - rs0 != 4) begin
            errors++;
            $display("FAIL rr_counts got starts=%0d rsps=%0d, required 4 4", n_start - st0, n_rsp - rs0);
        end
    endtask

    task automatic test_timeout();
        int s, r;
        mdl_en = 1'b0;
        sb.push_back({1'b0, 32'h7FC00000, 1'b1});
        issue(1'b0, 32'h3F800000, 32'h3F800000, s);
        wait_rsp(TO + 20, r);
        checks++;
        if (s < 0 || r != s + 1 + TO) begin
            errors++;
            $display("FAIL timeout_latency got start=%0d rsp=%0d, required rsp=start+%0d", s, r, TO + 1);
        end
        mdl_en = 1'b1;
        repeat (TO) @(negedge clk);
        sb.push_back({1'b1, 32'h40800000, 1'b0});
        issue(1'b1, 32'h40000000, 32'h40000000, s);
        wait_rsp(30, r);
        checks++;
        if (s < 0 || r != s + 6) begin
            errors++;
            $display("FAIL after_timeout_latency got start=%0d rsp=%0d, required rsp=start+6", s, r);
        end
    endtask

    task automatic test_done_at_timeout();
        int s, r;
        mdl_lat = TO;
        sb.push_back({1'b0, 32'h40000000, 1'b0});
        issue(1'b0, 32'h3F800000, 32'h3F800000, s);
        wait_rsp(TO + 20, r);
        checks++;
        if (s < 0 || r != s + 1 + TO) begin
            errors++;
            $display("FAIL tie_timeout_latency got start=%0d rsp=%0d, required rsp=start+%0d", s, r, TO + 1);
        end
        mdl_lat = 5;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int s, r, rs0;
        issue(1'b0, 32'h3FC00000, 32'h40200000, s);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, add_start} !== 7'b0 ||
            {rsp_sum, add_a, add_b} !== 96'b0) begin
            errors++;
            $display("FAIL wait_reset_outputs got ctrl=%b sum=%h a=%h b=%h, required all zero",
                     {ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, add_start}, rsp_sum, add_a, add_b);
        end
        rs0 = n_rsp;
        repeat (10) @(negedge clk);
        checks++;
        if (n_rsp != rs0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_done got rsps=%0d busy=%0d, required 0 0", n_rsp - rs0, busy);
        end
        sb.push_back({1'b1, 32'h40000000, 1'b0});
        issue(1'b1, 32'h3F800000, 32'h3F800000, s);
        wait_rsp(30, r);
        @(negedge clk);
        checks++;
        if (s < 0 || r != s + 6 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_req got start=%0d rsp=%0d pending=%0d, required rsp=start+6 pending=0",
                     s, r, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_done_at_timeout();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpadd_arb.md
FPADD_ARB -- requirements
Module: fpadd_arb

Interface
REQ-001 Parameter TIMEOUT, default 100: maximum cycles in WAIT for add_done before an operation is abandoned.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req0, req1  in  1 each  requester operation request, held until ack.
REQ-005 a0, b0, a1, b1  in  32 each  IEEE-754 single operands, stable while req high.
REQ-006 ack0, ack1  out  1 each  one-cycle pulse: operands captured.
REQ-007 rsp_valid  out  1  one-cycle pulse: result available.
REQ-008 rsp_id  out  1  requester owning rsp_sum (0 or 1).
REQ-009 rsp_sum  out  32  result word.
REQ-010 rsp_err  out  1  result is a timeout, not a real sum.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 add_start  out  1  start pulse to the shared fpadd.
REQ-013 add_a, add_b  out  32 each  operands to fpadd, registered.
REQ-014 add_sum  in  32  fpadd result.
REQ-015 add_done  in  1  fpadd completion; valid in WAIT only.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT and RESP, all outputs registered.
REQ-017 IDLE: no req -> stay; any req -> grant one requester, latch its a/b into add_a/add_b, latch owner id, go START.
REQ-018 Arbitration SHALL be round-robin on pointer last_id: both requesting -> grant !last_id; one requesting -> grant it; last_id updated on each grant.
REQ-019 START, exactly one cycle: add_start=1, ack of granted requester=1, timer cleared, go WAIT.
REQ-020 Requesters SHALL drop req the cycle after seeing ack; req is ignored outside IDLE.
REQ-021 WAIT: add_start=0; add_done=1 -> capture add_sum into rsp_sum, rsp_err=0, go RESP.
REQ-022 WAIT: timer increments each cycle; timer==TIMEOUT-1 without add_done -> rsp_sum=32'h7FC00000, rsp_err=1, go RESP.
REQ-023 Simultaneous add_done and timeout expiry SHALL resolve as done (real sum, rsp_err=0).
REQ-024 RESP, exactly one cycle: rsp_valid=1 with rsp_id/rsp_sum/rsp_err stable, go IDLE.
REQ-025 rsp_id/rsp_sum/rsp_err SHALL hold their values until the next RESP.
REQ-026 Latency: req high in IDLE cycle N -> ack and add_start in N+1; add_done in cycle D -> rsp_valid in D+1; next grant no earlier than D+2.
REQ-027 add_done while in IDLE, START or RESP SHALL be ignored.
REQ-028 Only one operation SHALL be outstanding at the shared fpadd at any time.
REQ-029 Timer width SHALL be sufficient for TIMEOUT without wrap.

Reset
REQ-030 reset SHALL force IDLE, last_id=1 (req0 wins first tie), timer=0.
REQ-031 reset SHALL zero ack0, ack1, rsp_valid, rsp_id, rsp_sum, rsp_err, busy, add_start, add_a and add_b.
REQ-032 reset in any state, including mid-WAIT, SHALL discard the in-flight operation without rsp_valid or ack.
REQ-033 reset SHALL take precedence over all other inputs in the same cycle.

Verification (bench uses a behavioural fpadd with 5-cycle done latency)
REQ-034 req0 only, a0=3F800000, b0=3F800000 -> ack0 next cycle, rsp_valid with rsp_id=0, rsp_sum=40000000, rsp_err=0.
REQ-035 req0 and req1 same cycle after reset, a0/b0=3F800000/3F800000, a1/b1=3FC00000/40200000 -> req0 served first (40000000), then req1 (40800000, rsp_id=1).
REQ-036 Both held requesting for four operations -> grants alternate 0,1,0,1; exactly one add_start per rsp_valid.
REQ-037 Model never asserts add_done -> rsp_valid TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_sum=7FC00000; next request still served correctly.
REQ-038 reset pulsed in WAIT, then stale add_done -> no rsp_valid, all outputs zero, busy=0; subsequent req1 with 3F800000+3F800000 -> 40000000, rsp_id=1.
REQ-039 add_done asserted in the same cycle as timeout expiry -> rsp_err=0 with the real sum.
